// File: rtl/axi_wr_burst_split.sv
// rtl/axi_wr_burst_split.sv - AXI write burst splitter (max length / 4 KB) with merged B response
module axi_wr_burst_split #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int STRB_WIDTH    = DATA_WIDTH / 8,
    parameter int ID_WIDTH      = 8,
    parameter int MAX_BURST_LEN = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ID_WIDTH-1:0]   s_axi_awid,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [7:0]            s_axi_awlen,
    input  logic [2:0]            s_axi_awsize,
    input  logic [1:0]            s_axi_awburst,
    input  logic                  s_axi_awlock,
    input  logic [3:0]            s_axi_awcache,
    input  logic [2:0]            s_axi_awprot,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
    input  logic                  s_axi_wlast,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [ID_WIDTH-1:0]   s_axi_bid,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    output logic [ID_WIDTH-1:0]   m_axi_awid,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [7:0]            m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic                  m_axi_awlock,
    output logic [3:0]            m_axi_awcache,
    output logic [2:0]            m_axi_awprot,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_WIDTH-1:0] m_axi_wdata,
    output logic [STRB_WIDTH-1:0] m_axi_wstrb,
    output logic                  m_axi_wlast,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [ID_WIDTH-1:0]   m_axi_bid,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready
);

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] BURST_WRAP = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DATA,
        ST_WAIT_B,
        ST_RESP
    } state_t;

    state_t state, state_next;

    logic [ID_WIDTH-1:0]   id_q;
    logic [2:0]            size_q;
    logic [1:0]            burst_q;
    logic                  lock_q;
    logic [3:0]            cache_q;
    logic [2:0]            prot_q;
    logic [ADDR_WIDTH-1:0] awaddr_q;
    logic [7:0]            awlen_q;
    logic [8:0]            remaining_q;
    logic [8:0]            issued_q;
    logic [8:0]            bcnt_q;
    logic [1:0]            bresp_q;
    logic [7:0]            wcnt_q;

    logic                  aw_hs, maw_hs, w_hs, mb_hs, last_beat, b_path_open;
    logic [8:0]            bcnt_next;
    logic [ADDR_WIDTH-1:0] next_addr, plan_addr;
    logic [8:0]            plan_rem;
    logic [2:0]            plan_size;
    logic [1:0]            plan_burst;
    logic [12:0]           plan_off, to_4k, beats_4k, n_beats;
    logic [7:0]            plan_len;
    logic                  unused_inputs;

    function automatic logic [ADDR_WIDTH-1:0] align_addr(input logic [ADDR_WIDTH-1:0] a,
                                                         input logic [2:0] sz);
        align_addr = a & ~((ADDR_WIDTH'(1) << sz) - ADDR_WIDTH'(1));
    endfunction

    // Upstream WLAST is regenerated and downstream BID is replaced by the captured ID.
    assign unused_inputs = &{1'b0, s_axi_wlast, m_axi_bid};

    assign b_path_open = (state == ST_ISSUE) || (state == ST_DATA) || (state == ST_WAIT_B);
    assign aw_hs       = (state == ST_IDLE) && s_axi_awvalid;
    assign maw_hs      = (state == ST_ISSUE) && m_axi_awready;
    assign w_hs        = (state == ST_DATA) && s_axi_wvalid && m_axi_wready;
    assign mb_hs       = b_path_open && m_axi_bvalid;
    assign last_beat   = w_hs && (wcnt_q == 8'd0);
    assign bcnt_next   = bcnt_q + 9'(mb_hs);

    // Next sub-burst start: INCR continues after the previous one, FIXED keeps the address.
    assign next_addr = (burst_q == BURST_INCR)
                     ? align_addr(awaddr_q, size_q) + (ADDR_WIDTH'({1'b0, awlen_q} + 9'd1) << size_q)
                     : awaddr_q;

    // Sub-burst planning: from the new AW in IDLE, otherwise from the remainder after a last beat.
    always_comb begin
        plan_addr  = next_addr;
        plan_rem   = remaining_q - 9'd1;
        plan_size  = size_q;
        plan_burst = burst_q;
        if (state == ST_IDLE) begin
            plan_addr  = s_axi_awaddr;
            plan_rem   = {1'b0, s_axi_awlen} + 9'd1;
            plan_size  = s_axi_awsize;
            plan_burst = s_axi_awburst;
        end
        plan_off = {1'b0, plan_addr[11:0] & ~((12'd1 << plan_size) - 12'd1)};
        to_4k    = 13'd4096 - plan_off;
        beats_4k = to_4k >> plan_size;
        n_beats  = 13'(plan_rem);
        if (plan_burst != BURST_WRAP) begin
            if (n_beats > 13'(MAX_BURST_LEN)) begin
                n_beats = 13'(MAX_BURST_LEN);
            end
            if ((plan_burst == BURST_INCR) && (n_beats > beats_4k)) begin
                n_beats = beats_4k;
            end
        end
        plan_len = 8'(n_beats - 13'd1);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Burst bookkeeping: captured attributes, sub-burst command, beat and response counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_q        <= '0;
            size_q      <= '0;
            burst_q     <= '0;
            lock_q      <= 1'b0;
            cache_q     <= '0;
            prot_q      <= '0;
            awaddr_q    <= '0;
            awlen_q     <= '0;
            remaining_q <= '0;
            issued_q    <= '0;
            bcnt_q      <= '0;
            bresp_q     <= 2'b00;
            wcnt_q      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (aw_hs) begin
                        id_q        <= s_axi_awid;
                        size_q      <= s_axi_awsize;
                        burst_q     <= s_axi_awburst;
                        lock_q      <= s_axi_awlock;
                        cache_q     <= s_axi_awcache;
                        prot_q      <= s_axi_awprot;
                        remaining_q <= plan_rem;
                        issued_q    <= '0;
                        bcnt_q      <= '0;
                        bresp_q     <= 2'b00;
                        awaddr_q    <= plan_addr;
                        awlen_q     <= plan_len;
                    end
                end
                ST_ISSUE: begin
                    if (maw_hs) begin
                        issued_q <= issued_q + 9'd1;
                        wcnt_q   <= awlen_q;
                    end
                end
                ST_DATA: begin
                    if (w_hs) begin
                        wcnt_q      <= wcnt_q - 8'd1;
                        remaining_q <= remaining_q - 9'd1;
                        if (last_beat && (remaining_q != 9'd1)) begin
                            awaddr_q <= plan_addr;
                            awlen_q  <= plan_len;
                        end
                    end
                end
                default: ;
            endcase
            if (mb_hs) begin
                bcnt_q <= bcnt_next;
                if (m_axi_bresp > bresp_q) begin
                    bresp_q <= m_axi_bresp;
                end
            end
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next    = state;
        s_axi_awready = 1'b0;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        s_axi_wready  = 1'b0;
        m_axi_wlast   = 1'b0;
        m_axi_bready  = b_path_open;
        s_axi_bvalid  = 1'b0;
        case (state)
            ST_IDLE: begin
                s_axi_awready = !rst;
                if (aw_hs) begin
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                m_axi_awvalid = 1'b1;
                if (maw_hs) begin
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                m_axi_wvalid = s_axi_wvalid;
                s_axi_wready = m_axi_wready;
                m_axi_wlast  = (wcnt_q == 8'd0);
                if (last_beat) begin
                    state_next = (remaining_q == 9'd1) ? ST_WAIT_B : ST_ISSUE;
                end
            end
            ST_WAIT_B: begin
                if (bcnt_next == issued_q) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                s_axi_bvalid = 1'b1;
                if (s_axi_bready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign m_axi_awid    = id_q;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awlen   = awlen_q;
    assign m_axi_awsize  = size_q;
    assign m_axi_awburst = burst_q;
    assign m_axi_awlock  = lock_q;
    assign m_axi_awcache = cache_q;
    assign m_axi_awprot  = prot_q;
    assign m_axi_wdata   = s_axi_wdata;
    assign m_axi_wstrb   = s_axi_wstrb;
    assign s_axi_bid     = id_q;
    assign s_axi_bresp   = bresp_q;

endmodule

// File: tb/tb_axi_wr_burst_split.sv
// tb/tb_axi_wr_burst_split.sv - self-checking bench for axi_wr_burst_split
module tb_axi_wr_burst_split;

    localparam int MAXB = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  s_axi_awid;
    logic [31:0] s_axi_awaddr;
    logic [7:0]  s_axi_awlen;
    logic [2:0]  s_axi_awsize;
    logic [1:0]  s_axi_awburst;
    logic        s_axi_awlock;
    logic [3:0]  s_axi_awcache;
    logic [2:0]  s_axi_awprot;
    logic        s_axi_awvalid, s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wlast, s_axi_wvalid, s_axi_wready;
    logic [7:0]  s_axi_bid;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid, s_axi_bready;
    logic [7:0]  m_axi_awid;
    logic [31:0] m_axi_awaddr;
    logic [7:0]  m_axi_awlen;
    logic [2:0]  m_axi_awsize;
    logic [1:0]  m_axi_awburst;
    logic        m_axi_awlock;
    logic [3:0]  m_axi_awcache;
    logic [2:0]  m_axi_awprot;
    logic        m_axi_awvalid, m_axi_awready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic [7:0]  m_axi_bid;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid, m_axi_bready;

    always #5 clk = ~clk;

    axi_wr_burst_split #(.MAX_BURST_LEN(MAXB)) dut (
        .clk(clk), .rst(rst),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awlock(s_axi_awlock),
        .s_axi_awcache(s_axi_awcache), .s_axi_awprot(s_axi_awprot),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
        .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic        aw_pend;
    logic [39:0] exp_aw_q[$];
    logic [36:0] exp_w_q[$];
    logic [35:0] w_q[$];
    logic [1:0]  resp_plan[$];
    logic [31:0] obs_addr[$];
    logic [7:0]  obs_len[$];
    logic [1:0]  obs_bresp;
    int          b_elig, b_sent, n_sub, sb_count, w_acc, aw_hs_cyc, last_b_cyc, aw_stall;
    bit          maw_seen, sb_seen;
    int          w_pct, mw_pct, maw_pct, b_pct, sb_pct;
    logic [7:0]  exp_id;
    logic [2:0]  exp_size, exp_prot;
    logic [1:0]  exp_burst, exp_resp;
    logic        exp_lock;
    logic [3:0]  exp_cache;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // One clock: drive at the falling edge, observe settled handshakes 1 ns later.
    task automatic cycle();
        logic [39:0] front;
        logic [36:0] wexp;
        @(negedge clk);
        cyc++;
        s_axi_awvalid = aw_pend;
        s_axi_wvalid  = (w_q.size() > 0) && ($urandom_range(0, 99) < w_pct);
        if (w_q.size() > 0) {s_axi_wstrb, s_axi_wdata} = w_q[0];
        else {s_axi_wstrb, s_axi_wdata} = 36'($urandom);
        s_axi_wlast   = 1'($urandom);
        if (m_axi_awvalid && aw_stall > 0) begin
            m_axi_awready = 1'b0;
            aw_stall--;
        end else begin
            m_axi_awready = ($urandom_range(0, 99) < maw_pct);
        end
        m_axi_wready = ($urandom_range(0, 99) < mw_pct);
        m_axi_bvalid = (b_elig > b_sent) && ($urandom_range(0, 99) < b_pct);
        m_axi_bresp  = (b_sent < resp_plan.size()) ? resp_plan[b_sent] : 2'b00;
        m_axi_bid    = 8'($urandom);
        s_axi_bready = ($urandom_range(0, 99) < sb_pct);
        #1;
        if (m_axi_awvalid && !maw_seen) begin
            maw_seen = 1'b1;
            chk("m_aw_latency", 64'(cyc), 64'(aw_hs_cyc + 1));
        end
        if (s_axi_awvalid && s_axi_awready) begin
            aw_pend = 1'b0;
            aw_hs_cyc = cyc;
            maw_seen = 1'b0;
        end
        if (m_axi_awvalid && m_axi_awready) begin
            if (exp_aw_q.size() == 0) begin
                chk("m_aw_unexpected", 64'(m_axi_awvalid), 64'(0));
            end else begin
                front = exp_aw_q.pop_front();
                chk("m_aw_addr", 64'(m_axi_awaddr), 64'(front[39:8]));
                chk("m_aw_len", 64'(m_axi_awlen), 64'(front[7:0]));
                chk("m_aw_attr", 64'({m_axi_awid, m_axi_awsize, m_axi_awburst, m_axi_awlock, m_axi_awcache, m_axi_awprot}),
                    64'({exp_id, exp_size, exp_burst, exp_lock, exp_cache, exp_prot}));
            end
            obs_addr.push_back(m_axi_awaddr);
            obs_len.push_back(m_axi_awlen);
        end
        if (s_axi_wvalid && s_axi_wready && w_q.size() > 0) w_q.delete(0);
        if (m_axi_wvalid && m_axi_wready) begin
            if (exp_w_q.size() == 0) begin
                chk("m_w_unexpected", 64'(m_axi_wvalid), 64'(0));
            end else begin
                wexp = exp_w_q.pop_front();
                chk("m_w_beat", 64'({m_axi_wlast, m_axi_wstrb, m_axi_wdata}), 64'(wexp));
                if (wexp[36]) b_elig++;
                w_acc++;
            end
        end
        if (m_axi_bvalid && m_axi_bready) begin
            b_sent++;
            last_b_cyc = cyc;
        end
        if (s_axi_bvalid && !sb_seen) begin
            sb_seen = 1'b1;
            chk("s_b_after_all_m_b", 64'(b_sent), 64'(n_sub));
            chk("s_b_latency", 64'(cyc), 64'(last_b_cyc + 1));
        end
        if (s_axi_bvalid && s_axi_bready) begin
            chk("s_b_id", 64'(s_axi_bid), 64'(exp_id));
            chk("s_b_resp", 64'(s_axi_bresp), 64'(exp_resp));
            obs_bresp = s_axi_bresp;
            sb_count++;
        end
    endtask

    // Reference plan: carve the burst into sub-bursts by length and 4 KB page limits.
    task automatic start_burst(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                               input logic [2:0] size, input logic [1:0] burst, input int resp_mode);
        longint a, al, page_end, sz_b;
        int rem, n;
        logic [31:0] d;
        logic [3:0] s;
        exp_aw_q.delete(); exp_w_q.delete(); w_q.delete(); resp_plan.delete();
        obs_addr.delete(); obs_len.delete();
        b_elig = 0; b_sent = 0; sb_count = 0; w_acc = 0; last_b_cyc = -10;
        maw_seen = 1'b1; sb_seen = 1'b0; obs_bresp = 2'bxx;
        rem = int'(len) + 1;
        a = longint'(addr);
        sz_b = longint'(1) << size;
        while (rem > 0) begin
            al = a - (a % sz_b);
            if (burst == 2'b10) begin
                n = rem;
            end else begin
                n = (rem < MAXB) ? rem : MAXB;
                if (burst == 2'b01) begin
                    page_end = (al / 4096 + 1) * 4096;
                    if ((page_end - al) / sz_b < longint'(n)) n = int'((page_end - al) / sz_b);
                end
            end
            exp_aw_q.push_back({32'(a), 8'(n - 1)});
            for (int j = 0; j < n; j++) begin
                d = $urandom;
                s = 4'($urandom);
                w_q.push_back({s, d});
                exp_w_q.push_back({(j == n - 1), s, d});
            end
            rem -= n;
            if (burst == 2'b01) a = al + longint'(n) * sz_b;
        end
        n_sub = exp_aw_q.size();
        exp_resp = 2'b00;
        for (int i = 0; i < n_sub; i++) begin
            case (resp_mode)
                1: resp_plan.push_back(2'($urandom));
                2: resp_plan.push_back((i == n_sub - 1) ? 2'b10 : 2'b00);
                3: resp_plan.push_back((i == 1) ? 2'b11 : 2'b00);
                default: resp_plan.push_back(2'b00);
            endcase
            if (resp_plan[i] > exp_resp) exp_resp = resp_plan[i];
        end
        exp_id = id; exp_size = size; exp_burst = burst;
        exp_lock = 1'($urandom); exp_cache = 4'($urandom); exp_prot = 3'($urandom);
        s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len; s_axi_awsize = size;
        s_axi_awburst = burst; s_axi_awlock = exp_lock; s_axi_awcache = exp_cache; s_axi_awprot = exp_prot;
        aw_pend = 1'b1;
    endtask

    task automatic finish_burst();
        for (int t = 0; t < 4000 && sb_count == 0; t++) cycle();
        chk("burst_done", 64'(sb_count), 64'(1));
        repeat (4) cycle();
        chk("single_s_b", 64'(sb_count), 64'(1));
        chk("aw_all_issued", 64'(exp_aw_q.size()), 64'(0));
        chk("w_all_sent", 64'(exp_w_q.size()), 64'(0));
    endtask

    task automatic set_pcts(input int p);
        w_pct = p; mw_pct = p; maw_pct = p; b_pct = p; sb_pct = p;
    endtask

    initial begin
        logic [31:0] ra;
        logic [1:0]  rb;
        logic [7:0]  rl;
        rst = 1'b1;
        aw_pend = 1'b0; aw_stall = 0; n_sub = 0; aw_hs_cyc = -10;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
        s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = '0;
        s_axi_awburst = '0; s_axi_awlock = 1'b0; s_axi_awcache = '0; s_axi_awprot = '0;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = '0; m_axi_bid = '0;
        set_pcts(100);
        repeat (3) @(negedge clk);
        #1;
        chk("reset_awready", 64'(s_axi_awready), 64'(0));
        chk("reset_valids", 64'({m_axi_awvalid, m_axi_wvalid, s_axi_bvalid, m_axi_bready}), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("idle_awready", 64'(s_axi_awready), 64'(1));

        // Two 16-beat sub-bursts from a 32-beat INCR burst.
        start_burst(8'h5A, 32'h0000_0000, 8'd31, 3'd2, 2'b01, 0);
        finish_burst();
        chk("t1_aw0_addr", 64'(obs_addr[0]), 64'h00);
        chk("t1_aw1_addr", 64'(obs_addr[1]), 64'h40);
        chk("t1_aw1_len", 64'(obs_len[1]), 64'd15);

        // 4 KB crossing.
        start_burst(8'h11, 32'h0000_0FF8, 8'd3, 3'd2, 2'b01, 0);
        finish_burst();
        chk("t2_aw1_addr", 64'(obs_addr[1]), 64'h1000);
        chk("t2_aw1_len", 64'(obs_len[1]), 64'd1);

        // Response merging.
        start_burst(8'h22, 32'h0000_2000, 8'd31, 3'd2, 2'b01, 2);
        finish_burst();
        chk("t3_slverr", 64'(obs_bresp), 64'(2'b10));
        start_burst(8'h33, 32'h0000_3000, 8'd47, 3'd2, 2'b01, 3);
        finish_burst();
        chk("t3_decerr", 64'(obs_bresp), 64'(2'b11));

        // Single beat.
        start_burst(8'h44, 32'h0000_0100, 8'd0, 3'd2, 2'b01, 0);
        finish_burst();
        chk("t4_n_sub", 64'(obs_len.size()), 64'd1);

        // Burst ending exactly on 4 KB: no empty tail.
        start_burst(8'h55, 32'h0000_0F00, 8'd63, 3'd2, 2'b01, 0);
        finish_burst();
        chk("t_4k_end_n_sub", 64'(obs_len.size()), 64'd4);

        // FIXED and WRAP.
        start_burst(8'h66, 32'h0000_4FFC, 8'd20, 3'd2, 2'b00, 1);
        finish_burst();
        start_burst(8'h67, 32'h0000_5FF0, 8'd15, 3'd2, 2'b10, 1);
        finish_burst();

        // Back-pressure: AW stall and 50% ready/valid.
        set_pcts(50);
        aw_stall = 5;
        start_burst(8'h77, 32'h0000_0000, 8'd31, 3'd2, 2'b01, 1);
        finish_burst();

        // Reset in the middle of a data phase.
        set_pcts(100);
        start_burst(8'h5A, 32'h0000_0000, 8'd31, 3'd2, 2'b01, 0);
        for (int t = 0; t < 2000 && w_acc < 5; t++) cycle();
        @(negedge clk);
        rst = 1'b1;
        aw_pend = 1'b0;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; m_axi_bvalid = 1'b0;
        #1;
        chk("mid_rst_awready", 64'(s_axi_awready), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_valids", 64'({m_axi_awvalid, m_axi_wvalid, s_axi_bvalid, m_axi_bready}), 64'(0));
        start_burst(8'h5B, 32'h0000_0000, 8'd31, 3'd2, 2'b01, 0);
        finish_burst();

        // Randomized bursts.
        for (int k = 0; k < 14; k++) begin
            set_pcts($urandom_range(50, 100));
            aw_stall = $urandom_range(0, 3);
            ra = ($urandom_range(0, 200) << 12) |
                 (($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 4095)) : 32'(4096 - $urandom_range(1, 64)));
            case ($urandom_range(0, 5))
                0: rb = 2'b00;
                1: rb = 2'b10;
                default: rb = 2'b01;
            endcase
            if (rb == 2'b10) rl = 8'((2 << $urandom_range(0, 3)) - 1);
            else rl = 8'($urandom_range(0, 255));
            start_burst(8'($urandom), ra, rl, 3'($urandom_range(0, 2)), rb, 1);
            finish_burst();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
